// File: rtl/rv32i_multicycle.sv
// rv32i_multicycle: non-pipelined RV32I integer core (OP, OP-IMM, LUI; optional BRANCH/JAL).
// Latency: 4 cycles per instruction after imem_ack is sampled (DECODE, EXECUTE, WRITEBACK, next FETCH).
// Backpressure: FETCH holds imem_req/imem_addr indefinitely until imem_ack; HALT is sticky until rst.
// Optional feature macro: RV32I_MULTICYCLE_BRANCH_EN enables BEQ/BNE/BLT/BGE/BLTU/BGEU and JAL.
module rv32i_multicycle #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            halt,
  output logic            illegal
);

`ifdef RV32I_MULTICYCLE_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  // shift-amount width and register-index width actually decoded
  localparam int SHW = (XLEN == 64) ? 6 : 5;
  localparam int RW  = (NREG == 16) ? 4 : 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_rs1v;
  logic [XLEN-1:0] r_rs2v;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_npc;
  logic [XLEN-1:0] r_result;
  logic            r_result_valid;
  logic            r_illegal;
  logic [XLEN-1:0] r_rf [NREG];

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [RW-1:0]   w_rs1_idx;
  logic [RW-1:0]   w_rs2_idx;
  logic [RW-1:0]   w_rd_idx;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_sel;
  logic [XLEN-1:0] w_rs1v;
  logic [XLEN-1:0] w_rs2v;
  logic            w_shf_hi_zero;
  logic            w_shf_hi_sra;
  logic            w_legal;
  logic            w_sys;
  logic            w_writes;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_we;
  logic [XLEN-1:0] w_opb;
  logic [SHW-1:0]  w_shamt;
  logic            w_lt;
  logic            w_ltu;
  logic            w_taken;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_npc;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_opcode  = r_ir[6:0];
  assign w_rd      = r_ir[11:7];
  assign w_f3      = r_ir[14:12];
  assign w_f7      = r_ir[31:25];
  assign w_rs1_idx = r_ir[15 +: RW];
  assign w_rs2_idx = r_ir[20 +: RW];
  assign w_rd_idx  = r_ir[7 +: RW];

  // sign-extended immediates for each format
  assign w_imm_i = XLEN'($signed(r_ir[31:20]));
  assign w_imm_u = XLEN'($signed({r_ir[31:12], 12'h000}));
  assign w_imm_b = XLEN'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0}));
  assign w_imm_j = XLEN'($signed({r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0}));

  // x0 is hardwired to zero on read
  assign w_rs1v = (r_ir[19:15] == 5'd0) ? '0 : r_rf[w_rs1_idx];
  assign w_rs2v = (r_ir[24:20] == 5'd0) ? '0 : r_rf[w_rs2_idx];

  // bits above the shift amount must be zero (SLLI/SRLI) or the SRAI marker
  assign w_shf_hi_zero = (SHW == 5) ? (r_ir[31:25] == 7'h00) : (r_ir[31:26] == 6'h00);
  assign w_shf_hi_sra  = (SHW == 5) ? (r_ir[31:25] == 7'h20) : (r_ir[31:26] == 6'h10);

  assign w_pc_plus4 = r_pc + XLEN'(4);

  // register write only for writing instructions with a non-zero destination
  assign w_we = (r_state == S_WRITEBACK) && w_writes && (w_rd != 5'd0);

  // decode legality, register usage and the immediate selected for this format
  always_comb begin
    w_legal   = 1'b0;
    w_sys     = 1'b0;
    w_writes  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_imm_sel = w_imm_i;
    case (w_opcode)
      OPC_OP: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_writes  = 1'b1;
        w_legal   = (w_f7 == 7'h00) ||
                    ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
      end
      OPC_OPIMM: begin
        w_use_rs1 = 1'b1;
        w_writes  = 1'b1;
        case (w_f3)
          3'b001:  w_legal = w_shf_hi_zero;
          3'b101:  w_legal = w_shf_hi_zero || w_shf_hi_sra;
          default: w_legal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        w_writes  = 1'b1;
        w_legal   = 1'b1;
        w_imm_sel = w_imm_u;
      end
      OPC_BRANCH: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm_sel = w_imm_b;
        w_legal   = BR_EN && (w_f3 != 3'b010) && (w_f3 != 3'b011);
      end
      OPC_JAL: begin
        w_writes  = 1'b1;
        w_imm_sel = w_imm_j;
        w_legal   = BR_EN;
      end
      OPC_SYSTEM: begin
        w_sys = (r_ir == 32'h0000_0073) || (r_ir == 32'h0010_0073);
      end
      default: ;
    endcase
    // reduced register file: any referenced index with bit 4 set is unsupported
    if ((NREG == 16) &&
        ((w_writes && r_ir[11]) || (w_use_rs1 && r_ir[19]) || (w_use_rs2 && r_ir[24]))) begin
      w_legal = 1'b0;
    end
  end

  // single ALU operation plus branch/jump target resolution
  always_comb begin
    w_opb   = ((w_opcode == OPC_OP) || (w_opcode == OPC_BRANCH)) ? r_rs2v : r_imm;
    w_shamt = w_opb[SHW-1:0];
    w_lt    = $signed(r_rs1v) < $signed(w_opb);
    w_ltu   = r_rs1v < w_opb;
    case (w_f3)
      3'b000:  w_alu = ((w_opcode == OPC_OP) && r_ir[30]) ? (r_rs1v - w_opb) : (r_rs1v + w_opb);
      3'b001:  w_alu = r_rs1v << w_shamt;
      3'b010:  w_alu = XLEN'(w_lt);
      3'b011:  w_alu = XLEN'(w_ltu);
      3'b100:  w_alu = r_rs1v ^ w_opb;
      3'b101:  w_alu = r_ir[30] ? XLEN'($signed(r_rs1v) >>> w_shamt) : (r_rs1v >> w_shamt);
      3'b110:  w_alu = r_rs1v | w_opb;
      default: w_alu = r_rs1v & w_opb;
    endcase
    case (w_f3)
      3'b000:  w_taken = (r_rs1v == r_rs2v);
      3'b001:  w_taken = (r_rs1v != r_rs2v);
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = !w_lt;
      3'b110:  w_taken = w_ltu;
      default: w_taken = !w_ltu;
    endcase
    w_npc = w_pc_plus4;
    if (w_opcode == OPC_LUI) begin
      w_alu = r_imm;
    end
    if (BR_EN && (w_opcode == OPC_JAL)) begin
      w_alu = w_pc_plus4;
      w_npc = r_pc + r_imm;
    end
    if (BR_EN && (w_opcode == OPC_BRANCH) && w_taken) begin
      w_npc = r_pc + r_imm;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state and fetch request; request is dropped while reset is held
  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = rst;
        if (imem_ack) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE:    w_next = w_legal ? S_EXECUTE : S_HALT;
      S_EXECUTE:   w_next = S_WRITEBACK;
      S_WRITEBACK: w_next = S_FETCH;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_HALT;
    endcase
  end

  // datapath registers, register file and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc           <= RESET_PC;
      r_ir           <= '0;
      r_rs1v         <= '0;
      r_rs2v         <= '0;
      r_imm          <= '0;
      r_alu          <= '0;
      r_npc          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_illegal      <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      r_result_valid <= w_we;
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_ir <= imem_rdata;
          end
        end
        S_DECODE: begin
          r_rs1v <= w_rs1v;
          r_rs2v <= w_rs2v;
          r_imm  <= w_imm_sel;
          if (!w_legal) begin
            r_illegal <= !w_sys;
          end
        end
        S_EXECUTE: begin
          r_alu <= w_alu;
          r_npc <= w_npc;
        end
        S_WRITEBACK: begin
          if (w_we) begin
            r_rf[w_rd_idx] <= r_alu;
            r_result       <= r_alu;
          end
          r_pc <= r_npc;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr    = r_pc;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign halt         = (r_state == S_HALT);
  assign illegal      = r_illegal;

endmodule
